// File: rtl/mips_pkg.sv
// Shared datapath widths and arbiter state encoding for the MIPS memory subsystem.
package mips_pkg;

    localparam int MIPS_WIDTH  = 32;
    localparam int MIPS_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between fetch (I) and memory stage (D);
// D has fixed priority, each grant is held on the bus until mem_ack.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int WIDTH  = MIPS_WIDTH,
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [WIDTH-1:0]  i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WIDTH-1:0]  d_wdata,
    output logic [WIDTH-1:0]  d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    arb_state_t state, state_next;
    logic       discard;
    logic       elig_i, elig_d;
    logic       grant_i, grant_d;
    logic       ack_i, ack_d;

    always_comb begin
        // A requester whose ready pulse is out this cycle is already served.
        elig_d     = d_req & ~d_ready;
        elig_i     = i_req & ~i_ready & ~i_flush;
        ack_i      = (state == ARB_BUSY_I) & mem_ack;
        ack_d      = (state == ARB_BUSY_D) & mem_ack;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        state_next = state;
        case (state)
            ARB_IDLE: begin
                grant_d = elig_d;
                grant_i = elig_i & ~elig_d;
            end
            ARB_BUSY_I: begin
                grant_d = ack_i & elig_d;
                if (ack_i) state_next = ARB_IDLE;
            end
            ARB_BUSY_D: begin
                grant_i = ack_d & elig_i;
                if (ack_d) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
        if (grant_d)      state_next = ARB_BUSY_D;
        else if (grant_i) state_next = ARB_BUSY_I;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            discard   <= 1'b0;
            i_rdata   <= '0;
            i_ready   <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_next;
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            // Busy also spans the ready-pulse cycle of the completing access.
            busy    <= (state_next != ARB_IDLE) | ack_i | ack_d;

            if (ack_i) begin
                if (!(discard | i_flush)) begin
                    i_ready <= 1'b1;
                    i_rdata <= mem_rdata;
                end
                discard <= 1'b0;
            end else if ((state == ARB_BUSY_I) && i_flush) begin
                discard <= 1'b1;
            end

            if (ack_d) begin
                d_ready <= 1'b1;
                if (!mem_we) d_rdata <= mem_rdata;
            end

            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
            end else if (state_next == ARB_IDLE) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then randomized mixed traffic
// against a word-array memory model with random acknowledge latency.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req, i_flush, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ready, d_ready, mem_req, mem_we, busy;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] phys_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];
    logic [31:0] exp_i [$];
    logic [31:0] exp_d [$];
    logic [31:0] d_last;
    int          resp_lat;
    bit          in_txn;
    int          wait_cnt;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Memory slave: acks each request after resp_lat cycles (random 0-7 when negative).
    task automatic responder();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (mem_req) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                wait_cnt  = (resp_lat < 0) ? int'($urandom_range(0, 7)) : resp_lat;
            end else begin
                check("mem_we_stable", {31'd0, mem_we}, {31'd0, cap_we});
                check("mem_addr_stable", mem_addr, cap_addr);
                check("mem_wdata_stable", mem_wdata, cap_wdata);
            end
            if (wait_cnt == 0) begin
                mem_ack = 1'b1;
                if (mem_we) phys_mem[mem_addr[11:2]] = mem_wdata;
                else        mem_rdata = phys_mem[mem_addr[11:2]];
                in_txn = 1'b0;
            end else begin
                wait_cnt--;
            end
        end else begin
            in_txn = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        responder();
    endtask

    task automatic set_mem(input logic [31:0] addr, input logic [31:0] val);
        phys_mem[addr[11:2]] = val;
        ref_mem[addr[11:2]]  = val;
    endtask

    task automatic issue_fetch(input logic [31:0] addr);
        i_req  = 1'b1;
        i_addr = addr;
        exp_i.push_back(ref_mem[addr[11:2]]);
    endtask

    task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        if (we) ref_mem[addr[11:2]] = wdata;
        else    d_last = ref_mem[addr[11:2]];
        exp_d.push_back(d_last);
    endtask

    task automatic wait_i(input int limit);
        bit seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            tick();
            if (i_ready) begin
                seen  = 1'b1;
                i_req = 1'b0;
            end
        end
        if (!seen) flag_fail("i_ready_timeout");
    endtask

    task automatic wait_d(input int limit);
        bit seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            tick();
            if (d_ready) begin
                seen  = 1'b1;
                d_req = 1'b0;
            end
        end
        if (!seen) flag_fail("d_ready_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_i_rdata"}, i_rdata, 32'd0);
        check({tag, "_i_ready"}, {31'd0, i_ready}, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
        check({tag, "_d_ready"}, {31'd0, d_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every ready pulse consumes the oldest expectation for that requester.
    always @(negedge clk) begin
        if (i_ready === 1'b1) begin
            if (exp_i.size() == 0) flag_fail("i_ready_unexpected");
            else check("i_rdata", i_rdata, exp_i.pop_front());
        end
        if (d_ready === 1'b1) begin
            if (exp_d.size() == 0) flag_fail("d_ready_unexpected");
            else check("d_rdata", d_rdata, exp_d.pop_front());
        end
    end

    initial begin
        int          c0, d_at, i_at, ops;
        bit          ip, dp, seen;
        logic [31:0] k44;

        for (int a = 0; a < 1024; a++) begin
            phys_mem[a] = $urandom;
            ref_mem[a]  = phys_mem[a];
        end
        reset_n = 1'b0;
        i_req = 1'b0; i_flush = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        d_last = '0;
        resp_lat = 0;
        in_txn = 1'b0;
        wait_cnt = 0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Single fetch, ack in the first mem_req cycle.
        set_mem(32'h40, 32'h8C22_0004);
        tick();
        issue_fetch(32'h40);
        tick();
        check("f_mem_req", {31'd0, mem_req}, 32'd1);
        check("f_mem_addr", mem_addr, 32'h40);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        check("f_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        check("f_i_ready_c2", {31'd0, i_ready}, 32'd1);
        check("f_i_rdata_c2", i_rdata, 32'h8C22_0004);
        check("f_busy_c2", {31'd0, busy}, 32'd1);
        i_req = 1'b0;
        tick();
        check("f_busy_c3", {31'd0, busy}, 32'd0);
        check("f_i_ready_c3", {31'd0, i_ready}, 32'd0);

        // Simultaneous I and D requests: D first, I follows with no idle cycle.
        k44 = 32'hA1B2_C3D4;
        set_mem(32'h44, k44);
        set_mem(32'h100, 32'h0BAD_F00D);
        resp_lat = 3;
        issue_fetch(32'h44);
        issue_d(1'b0, 32'h100, 32'h0);
        c0 = cyc;
        d_at = -1;
        i_at = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (d_ready && d_at < 0) begin
                d_at  = cyc - c0;
                d_req = 1'b0;
                check("pri_next_mem_req", {31'd0, mem_req}, 32'd1);
                check("pri_next_mem_addr", mem_addr, 32'h44);
            end
            if (i_ready && i_at < 0) begin
                i_at  = cyc - c0;
                i_req = 1'b0;
            end
        end
        check("pri_d_ready_cycle", d_at, 32'd5);
        check("pri_i_ready_cycle", i_at, 32'd9);

        // Store: fields on the bus, d_rdata left unchanged.
        resp_lat = 2;
        issue_d(1'b1, 32'h54, 32'h7);
        tick();
        check("st_mem_we", {31'd0, mem_we}, 32'd1);
        check("st_mem_addr", mem_addr, 32'h54);
        check("st_mem_wdata", mem_wdata, 32'h7);
        wait_d(20);
        check("st_mem_content", phys_mem[32'h54 >> 2], 32'h7);

        // Flushed fetch: memory access completes, no ready, i_rdata kept.
        set_mem(32'h48, 32'hDEAD_BEEF);
        resp_lat = 3;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h48;
        tick();
        check("fl_mem_addr", mem_addr, 32'h48);
        i_req   = 1'b0;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (i_ready) seen = 1'b1;
        end
        check("fl_no_i_ready", {31'd0, seen}, 32'd0);
        check("fl_i_rdata_kept", i_rdata, k44);
        issue_fetch(32'h60);
        wait_i(20);

        // Reset while a load waits for its ack; a late ack must be ignored.
        resp_lat = 1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0;
        tick();
        tick();
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        d_req   = 1'b0;
        check_all_zero("rst_mid");
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        check("rst_late_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_late_d_rdata", d_rdata, 32'd0);
        check("rst_late_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rst_late_d_ready2", {31'd0, d_ready}, 32'd0);
        d_last = '0;

        // Randomized mixed traffic with random latency and occasional flushes.
        resp_lat = -1;
        ops = 0;
        ip = 1'b0;
        dp = 1'b0;
        for (int n = 0; n < 40000 && !(ops >= 1000 && !ip && !dp); n++) begin
            tick();
            i_flush = 1'b0;
            if (ip && i_ready) begin ip = 1'b0; i_req = 1'b0; end
            if (dp && d_ready) begin dp = 1'b0; d_req = 1'b0; end
            if (ip && $urandom_range(0, 39) == 0) begin
                i_flush = 1'b1;
                i_req   = 1'b0;
                ip      = 1'b0;
                void'(exp_i.pop_back());
            end else if (!ip && ops < 1000 && $urandom_range(0, 1) == 0) begin
                issue_fetch({21'd0, 9'($urandom), 2'b00});
                ip = 1'b1;
                ops++;
            end
            if (!dp && ops < 1000 && $urandom_range(0, 2) == 0) begin
                issue_d(1'($urandom), {20'd0, 1'b1, 9'($urandom), 2'b00}, $urandom);
                dp = 1'b1;
                ops++;
            end
        end
        if (ip || dp) flag_fail("random_drain_timeout");
        tick();
        tick();
        check("exp_i_empty", exp_i.size(), 32'd0);
        check("exp_d_empty", exp_d.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
